// File: rtl/int_arbiter_pkg.sv
// Shared definitions for the interrupt arbiter: code width, register map and FSM states.
`ifndef INT_CODE_WIDTH
`define INT_CODE_WIDTH 5
`endif

package int_arbiter_pkg;

  // Source indices fit in 5 bits because at most 31 sources are supported.
  localparam int ID_W = 5;

  localparam logic [1:0] ADDR_ENABLE  = 2'd0;
  localparam logic [1:0] ADDR_PENDING = 2'd1;
  localparam logic [1:0] ADDR_CLAIM   = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_NOTIFY  = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

  // Interrupt code as seen by software: source i is reported as i+1.
  function automatic logic [31:0] code_word(input logic [ID_W-1:0] id);
    return 32'(id) + 32'd1;
  endfunction

endpackage

// File: rtl/int_arbiter_if.sv
// Register/interrupt bundle between the arbiter and its bus master / CSR side.
interface int_arbiter_if #(
  parameter int NUM_SRC = 8,
  parameter int CODE_W  = `INT_CODE_WIDTH
);

  logic [NUM_SRC-1:0] irq_src;
  logic [1:0]         reg_addr;
  logic               reg_ren;
  logic               reg_wen;
  logic [31:0]        reg_wdata;
  logic [31:0]        reg_rdata;
  logic [CODE_W-1:0]  int_code;
  logic               busy;

  modport master (
    output irq_src, reg_addr, reg_ren, reg_wen, reg_wdata,
    input  reg_rdata, int_code, busy
  );

  modport slave (
    input  irq_src, reg_addr, reg_ren, reg_wen, reg_wdata,
    output reg_rdata, int_code, busy
  );

endinterface

// File: rtl/int_arbiter_rr_pick.sv
// Combinational round-robin selector: first requester above last_id, wrapping to 0.
module rr_pick
  import int_arbiter_pkg::*;
#(
  parameter int NUM_SRC = 8
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [ID_W-1:0]    last_id,
  output logic               valid,
  output logic [ID_W-1:0]    id
);

  // Lowest requester at or below last_id is the fallback; lowest above last_id overrides it.
  always_comb begin
    valid = 1'b0;
    id    = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req[i] && (i <= int'(last_id))) begin
        valid = 1'b1;
        id    = ID_W'(i);
      end
    end
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req[i] && (i > int'(last_id))) begin
        valid = 1'b1;
        id    = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/int_arbiter.sv
// Peripheral interrupt arbiter: edge capture, enable mask, round-robin grant,
// claim/complete handshake and a single-code output toward the CSR file.
module int_arbiter
  import int_arbiter_pkg::*;
#(
  parameter int NUM_SRC = 8,
  parameter int CODE_W  = `INT_CODE_WIDTH
) (
  input  logic          clk,
  input  logic          rst,
  int_arbiter_if.slave  bus
);

  localparam logic [ID_W-1:0] LAST_ID_RESET = ID_W'(NUM_SRC - 1);

  state_t             state;
  state_t             state_next;
  logic [NUM_SRC-1:0] irq_prev;
  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] enable;
  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] clear_mask;
  logic [NUM_SRC-1:0] req;
  logic [ID_W-1:0]    win_id;
  logic [ID_W-1:0]    last_id;
  logic [ID_W-1:0]    pick_id;
  logic               pick_valid;
  logic               claim_rd;
  logic               enable_wr;
  logic               complete_wr;
  logic               drop_win;
  logic [31:0]        win_code;

  assign rise        = bus.irq_src & ~irq_prev;
  assign req         = pending & enable;
  assign win_code    = code_word(win_id);
  assign claim_rd    = bus.reg_ren && (bus.reg_addr == ADDR_CLAIM);
  assign enable_wr   = bus.reg_wen && (bus.reg_addr == ADDR_ENABLE);
  assign complete_wr = bus.reg_wen && (bus.reg_addr == ADDR_CLAIM) && (bus.reg_wdata == win_code);
  assign drop_win    = enable_wr && !bus.reg_wdata[win_id];
  assign clear_mask  = (state == ST_NOTIFY && claim_rd) ? (NUM_SRC'(1) << win_id) : '0;

  rr_pick #(
    .NUM_SRC (NUM_SRC)
  ) u_pick (
    .req     (req),
    .last_id (last_id),
    .valid   (pick_valid),
    .id      (pick_id)
  );

  // Capture rising edges into pending (a new edge beats a same-cycle claim) and hold the enable mask.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      irq_prev <= '0;
      pending  <= '0;
      enable   <= '0;
    end else begin
      irq_prev <= bus.irq_src;
      pending  <= (pending & ~clear_mask) | rise;
      if (enable_wr) begin
        enable <= bus.reg_wdata[NUM_SRC-1:0];
      end
    end
  end

  // Latch the winner when granting and remember it as last_id once software completes it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      win_id  <= '0;
      last_id <= LAST_ID_RESET;
    end else begin
      if (state == ST_IDLE && pick_valid) begin
        win_id <= pick_id;
      end
      if (state == ST_SERVICE && complete_wr) begin
        last_id <= win_id;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: grant, claim or withdraw, complete.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (pick_valid) begin
          state_next = ST_NOTIFY;
        end
      end
      ST_NOTIFY: begin
        if (claim_rd) begin
          state_next = ST_SERVICE;
        end else if (drop_win) begin
          state_next = ST_IDLE;
        end
      end
      ST_SERVICE: begin
        if (complete_wr) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Outputs decoded from registered state, so the code is only ever visible while notifying.
  always_comb begin
    bus.int_code = '0;
    bus.busy     = 1'b0;
    if (state == ST_NOTIFY) begin
      bus.int_code = CODE_W'(win_id) + CODE_W'(1);
    end
    if (state == ST_SERVICE) begin
      bus.busy = 1'b1;
    end
  end

  // Registered read port; the value holds until the next read strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.reg_rdata <= '0;
    end else if (bus.reg_ren) begin
      case (bus.reg_addr)
        ADDR_ENABLE:  bus.reg_rdata <= 32'(enable);
        ADDR_PENDING: bus.reg_rdata <= 32'(pending);
        ADDR_CLAIM:   bus.reg_rdata <= (state == ST_NOTIFY) ? win_code : 32'd0;
        default:      bus.reg_rdata <= 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_int_arbiter.sv
// Testbench for int_arbiter: directed scenarios plus random traffic against a behavioural model.
module tb_int_arbiter;

  localparam int NSRC = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;
  logic [NSRC-1:0] cur_irq = '0;

  // Behavioural model state
  logic [NSRC-1:0] m_pend;
  logic [NSRC-1:0] m_en;
  logic [NSRC-1:0] m_prev;
  bit              m_notify;
  bit              m_serve;
  int              m_win;
  int              m_last;
  logic [31:0]     m_rdata;

  int_arbiter_if #(.NUM_SRC(NSRC)) bus ();

  int_arbiter #(.NUM_SRC(NSRC)) dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    m_pend   = '0;
    m_en     = '0;
    m_prev   = '0;
    m_notify = 1'b0;
    m_serve  = 1'b0;
    m_win    = 0;
    m_last   = NSRC - 1;
    m_rdata  = '0;
  endtask

  // One clock of the arbiter's rules, written from the register-level description.
  task automatic modelStep(input logic [NSRC-1:0] irq, input logic [1:0] addr, input bit ren,
                           input bit wen, input logic [31:0] wdata);
    logic [NSRC-1:0] rise;
    logic [NSRC-1:0] nxt_pend;
    logic [NSRC-1:0] nxt_en;
    logic [NSRC-1:0] req;
    bit              nxt_notify;
    bit              nxt_serve;
    int              nxt_win;
    int              nxt_last;
    rise       = irq & ~m_prev;
    nxt_pend   = m_pend;
    nxt_en     = m_en;
    nxt_notify = m_notify;
    nxt_serve  = m_serve;
    nxt_win    = m_win;
    nxt_last   = m_last;
    if (ren) begin
      if (addr == 2'd0)      m_rdata = 32'(m_en);
      else if (addr == 2'd1) m_rdata = 32'(m_pend);
      else if (addr == 2'd2) m_rdata = m_notify ? 32'(m_win + 1) : 32'd0;
      else                   m_rdata = 32'd0;
    end
    if (wen && addr == 2'd0) nxt_en = wdata[NSRC-1:0];
    if (m_notify) begin
      if (ren && addr == 2'd2) begin
        nxt_pend[m_win] = 1'b0;
        nxt_notify      = 1'b0;
        nxt_serve       = 1'b1;
      end else if (wen && addr == 2'd0 && wdata[m_win] == 1'b0) begin
        nxt_notify = 1'b0;
      end
    end else if (m_serve) begin
      if (wen && addr == 2'd2 && wdata == 32'(m_win + 1)) begin
        nxt_serve = 1'b0;
        nxt_last  = m_win;
      end
    end else begin
      req = m_pend & m_en;
      for (int k = 1; k <= NSRC; k++) begin
        if (!nxt_notify && req[(m_last + k) % NSRC]) begin
          nxt_notify = 1'b1;
          nxt_win    = (m_last + k) % NSRC;
        end
      end
    end
    m_pend   = nxt_pend | rise;
    m_en     = nxt_en;
    m_prev   = irq;
    m_notify = nxt_notify;
    m_serve  = nxt_serve;
    m_win    = nxt_win;
    m_last   = nxt_last;
  endtask

  // Drive one cycle of inputs, advance the model, then compare all outputs at the falling edge.
  task automatic applyStimulus(input string step, input logic [NSRC-1:0] irq, input logic [1:0] addr,
                               input bit ren, input bit wen, input logic [31:0] wdata);
    bus.irq_src   = irq;
    bus.reg_addr  = addr;
    bus.reg_ren   = ren;
    bus.reg_wen   = wen;
    bus.reg_wdata = wdata;
    @(posedge clk);
    modelStep(irq, addr, ren, wen, wdata);
    @(negedge clk);
    checkOutput({step, ".int_code"}, 32'(bus.int_code), m_notify ? 32'(m_win + 1) : 32'd0);
    checkOutput({step, ".busy"}, 32'(bus.busy), 32'(m_serve));
    checkOutput({step, ".rdata"}, bus.reg_rdata, m_rdata);
    bus.reg_ren = 1'b0;
    bus.reg_wen = 1'b0;
  endtask

  task automatic idle(input string step);
    applyStimulus(step, cur_irq, 2'd0, 1'b0, 1'b0, 32'd0);
  endtask

  task automatic setIrq(input string step, input logic [NSRC-1:0] v);
    cur_irq = v;
    applyStimulus(step, cur_irq, 2'd0, 1'b0, 1'b0, 32'd0);
  endtask

  task automatic regRead(input string step, input logic [1:0] addr);
    applyStimulus(step, cur_irq, addr, 1'b1, 1'b0, 32'd0);
  endtask

  task automatic regWrite(input string step, input logic [1:0] addr, input logic [31:0] data);
    applyStimulus(step, cur_irq, addr, 1'b0, 1'b1, data);
  endtask

  task automatic doReset(input string step);
    rst_n         = 1'b0;
    cur_irq       = '0;
    bus.irq_src   = '0;
    bus.reg_addr  = 2'd0;
    bus.reg_ren   = 1'b0;
    bus.reg_wen   = 1'b0;
    bus.reg_wdata = 32'd0;
    @(posedge clk);
    @(negedge clk);
    modelReset();
    checkOutput({step, ".int_code"}, 32'(bus.int_code), 32'd0);
    checkOutput({step, ".busy"}, 32'(bus.busy), 32'd0);
    checkOutput({step, ".rdata"}, bus.reg_rdata, 32'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    int r;
    logic [1:0] a;
    $display("[TB] int_arbiter bench starting");
    doReset("reset0");
    regRead("rd_en_reset", 2'd0);
    checkOutput("enable_after_reset", bus.reg_rdata, 32'd0);

    // Single source grant, claim, wrong and right complete
    regWrite("en_ff", 2'd0, 32'hFF);
    setIrq("src3_rise", 8'h08);
    idle("src3_wait");
    checkOutput("src3_code", 32'(bus.int_code), 32'd4);
    regRead("claim4", 2'd2);
    checkOutput("claim4_rdata", bus.reg_rdata, 32'd4);
    checkOutput("claim4_code_cleared", 32'(bus.int_code), 32'd0);
    checkOutput("claim4_busy", 32'(bus.busy), 32'd1);
    regWrite("done5_wrong", 2'd2, 32'd5);
    checkOutput("wrong_complete_busy", 32'(bus.busy), 32'd1);
    regWrite("done4", 2'd2, 32'd4);
    checkOutput("complete4_busy", 32'(bus.busy), 32'd0);
    setIrq("src3_low", 8'h00);
    regRead("claim_idle", 2'd2);
    checkOutput("claim_idle_rdata", bus.reg_rdata, 32'd0);
    regWrite("en_wide", 2'd0, 32'hFFFF_FFFF);
    regRead("en_wide_rd", 2'd0);
    checkOutput("enable_upper_bits", bus.reg_rdata, 32'hFF);
    regWrite("pend_wr", 2'd1, 32'hFF);
    regWrite("addr3_wr", 2'd3, 32'hFF);
    regRead("pend_rd", 2'd1);
    checkOutput("pending_not_writable", bus.reg_rdata, 32'd0);

    // Round-robin order
    doReset("reset_rr");
    regWrite("rr_en", 2'd0, 32'hFF);
    setIrq("rr_rise15", 8'h22);
    idle("rr_wait");
    checkOutput("rr_first_src1", 32'(bus.int_code), 32'd2);
    regRead("rr_claim2", 2'd2);
    regWrite("rr_done2", 2'd2, 32'd2);
    idle("rr_pick5");
    checkOutput("rr_second_src5", 32'(bus.int_code), 32'd6);
    regRead("rr_claim6", 2'd2);
    regWrite("rr_done6", 2'd2, 32'd6);
    setIrq("rr_drop", 8'h00);
    setIrq("rr_rise16", 8'h42);
    idle("rr_wait2");
    checkOutput("rr_src6_before_src1", 32'(bus.int_code), 32'd7);
    regRead("rr_claim7", 2'd2);
    regWrite("rr_done7", 2'd2, 32'd7);
    idle("rr_pick1");
    checkOutput("rr_then_src1", 32'(bus.int_code), 32'd2);

    // Disabled source stays pending until enabled
    doReset("reset_mask");
    setIrq("mask_rise2", 8'h04);
    idle("mask_wait1");
    idle("mask_wait2");
    checkOutput("masked_code", 32'(bus.int_code), 32'd0);
    regRead("mask_pend_rd", 2'd1);
    checkOutput("masked_pending", bus.reg_rdata, 32'h4);
    regWrite("mask_en2", 2'd0, 32'h04);
    idle("mask_grant");
    checkOutput("unmasked_code", 32'(bus.int_code), 32'd3);

    // New edge in the same cycle as the claim keeps the source pending
    doReset("reset_race");
    regWrite("race_en", 2'd0, 32'hFF);
    setIrq("race_rise3", 8'h08);
    idle("race_wait");
    setIrq("race_low", 8'h00);
    cur_irq = 8'h08;
    applyStimulus("race_claim_rise", cur_irq, 2'd2, 1'b1, 1'b0, 32'd0);
    checkOutput("race_claim_rdata", bus.reg_rdata, 32'd4);
    regRead("race_pend_rd", 2'd1);
    checkOutput("race_pending_kept", bus.reg_rdata, 32'h08);
    regWrite("race_done4", 2'd2, 32'd4);
    idle("race_regrant");
    checkOutput("race_regrant_code", 32'(bus.int_code), 32'd4);

    // Withdrawing enable while notifying
    doReset("reset_withdraw");
    regWrite("wd_en", 2'd0, 32'hFF);
    setIrq("wd_rise0", 8'h01);
    idle("wd_wait");
    checkOutput("wd_code1", 32'(bus.int_code), 32'd1);
    regWrite("wd_disable", 2'd0, 32'h00);
    checkOutput("wd_code_dropped", 32'(bus.int_code), 32'd0);
    regRead("wd_pend_rd", 2'd1);
    checkOutput("wd_pending_kept", bus.reg_rdata, 32'h01);
    regRead("wd_claim_idle", 2'd2);
    checkOutput("wd_claim_returns0", bus.reg_rdata, 32'd0);

    // Reset during service drops the interrupt
    regWrite("rs_en", 2'd0, 32'hFF);
    idle("rs_wait");
    regRead("rs_claim", 2'd2);
    checkOutput("rs_busy_before", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("rs_async_busy", 32'(bus.busy), 32'd0);
    checkOutput("rs_async_rdata", bus.reg_rdata, 32'd0);
    doReset("rs_reset");

    // Random traffic
    regWrite("rnd_en", 2'd0, 32'hFF);
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 3) == 0) cur_irq = cur_irq ^ NSRC'($urandom);
      r = int'($urandom_range(0, 11));
      case (r)
        0, 1, 2: regRead("rnd_claim", 2'd2);
        3: begin
          a = 2'($urandom_range(0, 3));
          regRead("rnd_read", a);
        end
        4: regWrite("rnd_enable", 2'd0, ($urandom_range(0, 3) == 0) ? $urandom : 32'hFF);
        5, 6: regWrite("rnd_complete", 2'd2, 32'(m_win + 1));
        7: regWrite("rnd_bad_complete", 2'd2, 32'($urandom_range(0, 9)));
        8: regWrite("rnd_ro_write", ($urandom_range(0, 1) == 0) ? 2'd1 : 2'd3, $urandom);
        default: idle("rnd_idle");
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
